// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared byte type and transmit-sequencer state encoding for the
//               UART transmit path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_seq_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_mem
// Description : DEPTH x byte register array, one synchronous write port and
//               one asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [7:0]        i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data
);

    byte_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Byte FIFO plus launch sequencer feeding the UART transmitter,
//               pacing launches on the transmitter busy flag.
//               Optional build macro UART_TX_FIFO_STATS_EN adds the sticky
//               overflow flag and saturating dropped-write counter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     almost_full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);

    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam int                 c_CNT_W     = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AFULL_CNT = c_CNT_W'(AFULL_LVL);

    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    tx_seq_state_e      r_state;

    logic               w_push;
    logic               w_pop;
    logic [7:0]         w_rd_data;

    // Full comes from the registered count, so a same-cycle pop never
    // admits a write that arrived while full.
    assign full        = (r_count == c_DEPTH_CNT);
    assign almost_full = (r_count >= c_AFULL_CNT);
    assign empty       = (r_count == '0);
    assign count       = r_count;

    assign w_push = wr_en & ~full;
    assign w_pop  = (r_state == LAUNCH);

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_PTR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // LAUNCH is only entered with count != 0, so the pop never underflows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:      if (r_count != '0) r_state <= LAUNCH;
                LAUNCH:    r_state <= WAIT_BUSY;
                WAIT_BUSY: if (tx_busy)       r_state <= WAIT_DONE;
                WAIT_DONE: if (!tx_busy)      r_state <= IDLE;
                default:   r_state <= IDLE;
            endcase
        end
    end

    assign tx_start = (r_state == LAUNCH);
    assign tx_data  = tx_start ? w_rd_data : 8'h00;

`ifdef UART_TX_FIFO_STATS_EN
    logic        r_overflow;
    logic [15:0] r_drop_cnt;
    logic        w_drop;

    assign w_drop = wr_en & full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign overflow = r_overflow;
    assign drop_cnt = r_drop_cnt;
`else
    assign overflow = 1'b0;
    assign drop_cnt = 16'h0000;
`endif

endmodule : uart_tx_fifo
`default_nettype wire
